// File: rtl/stim_pkg.sv
// Shared types and constants for the timestamped stimulus replay engine.
// Entry layout in the event buffer is {delay, mask, data}, MSB first.
package stim_pkg;

    localparam int FIRED_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FIRE,
        ST_GAP
    } state_e;

    function automatic int entry_w(input int delay_w, input int num_in, input int data_w);
        return delay_w + num_in + num_in * data_w;
    endfunction

endpackage

// File: rtl/stim_fifo.sv
// Synchronous FIFO holding queued replay entries.
// Pointers carry one extra wrap bit so that full and empty are distinguishable.
module stim_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign fill    = wr_q - rd_q;
    assign head    = mem_q[rd_q[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/stim_event_player.sv
// Replays buffered (delay, mask, values) entries as one-cycle monitor input
// strobes, each followed by one idle cycle.
module stim_event_player
    import stim_pkg::*;
#(
    parameter int NUM_IN  = 1,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 16,
    parameter int DELAY_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [DELAY_W-1:0]         ld_delay,
    input  logic [NUM_IN-1:0]          ld_mask,
    input  logic [NUM_IN*DATA_W-1:0]   ld_data,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_IN-1:0]          new_input,
    output logic [NUM_IN*DATA_W-1:0]   input_data,
    output logic [$clog2(DEPTH):0]     fill,
    output logic [FIRED_CNT_W-1:0]     fired_cnt
);

    localparam int EW = entry_w(DELAY_W, NUM_IN, DATA_W);
    localparam int DW = NUM_IN * DATA_W;

    state_e                 state_q, state_d;
    logic [DELAY_W-1:0]     cnt_q, cnt_d;
    logic [NUM_IN-1:0]      cur_mask_q, cur_mask_d;
    logic [DW-1:0]          cur_data_q, cur_data_d;
    logic [NUM_IN-1:0]      new_input_q, new_input_d;
    logic [DW-1:0]          input_data_q, input_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [FIRED_CNT_W-1:0] fired_q, fired_d;

    logic [EW-1:0]          head;
    logic                   empty;
    logic                   full;
    logic                   pop;
    logic                   take;
    logic [DELAY_W-1:0]     hd_delay;
    logic [NUM_IN-1:0]      hd_mask;
    logic [DW-1:0]          hd_data;

    assign hd_delay = head[EW-1 -: DELAY_W];
    assign hd_mask  = head[DW +: NUM_IN];
    assign hd_data  = head[DW-1:0];

    assign ld_ready = (state_q == ST_IDLE) && !full;

    stim_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (en && ld_valid && ld_ready && !abort),
        .din   ({ld_delay, ld_mask, ld_data}),
        .pop   (en && pop),
        .flush (en && abort),
        .head  (head),
        .fill  (fill),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_mask_d   = cur_mask_q;
        cur_data_d   = cur_data_q;
        fired_d      = fired_q;
        done_d       = 1'b0;
        take         = 1'b0;
        pop          = 1'b0;
        new_input_d  = '0;
        input_data_d = '0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (!empty) begin
                            take    = 1'b1;
                            fired_d = '0;
                        end else begin
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) state_d = ST_FIRE;
                    else             cnt_d   = cnt_q - DELAY_W'(1);
                end
                ST_FIRE: begin
                    state_d = ST_GAP;
                    // done is registered, so it must be decided here to land in the GAP cycle
                    done_d  = empty;
                    if ((cur_mask_q != '0) && (fired_q != {FIRED_CNT_W{1'b1}}))
                        fired_d = fired_q + FIRED_CNT_W'(1);
                end
                ST_GAP: begin
                    if (!empty) take    = 1'b1;
                    else        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Counter is preloaded with d-1 so that delay d yields exactly d WAIT cycles
        if (take) begin
            pop        = 1'b1;
            cur_mask_d = hd_mask;
            cur_data_d = hd_data;
            if (hd_delay == '0) begin
                state_d = ST_FIRE;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = hd_delay - DELAY_W'(1);
            end
        end

        if (state_d == ST_FIRE) begin
            new_input_d = cur_mask_d;
            for (int k = 0; k < NUM_IN; k++) begin
                if (cur_mask_d[k]) input_data_d[k*DATA_W +: DATA_W] = cur_data_d[k*DATA_W +: DATA_W];
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            new_input_q  <= '0;
            input_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fired_q      <= '0;
        end else if (en) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            new_input_q  <= new_input_d;
            input_data_q <= input_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fired_q      <= fired_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            cur_mask_q <= cur_mask_d;
            cur_data_q <= cur_data_d;
        end
    end

    assign new_input  = new_input_q;
    assign input_data = input_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fired_cnt  = fired_q;

endmodule

// File: tb/tb_stim_event_player.sv
// Self-checking bench for stim_event_player (2 channels, 8-bit values, 4-entry buffer).
// Expected strobes and done pulses are queued with their cycle numbers when playback starts.
module tb_stim_event_player;

    localparam int NI = 2;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int LW = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b1;
    logic             ld_valid = 1'b0;
    logic [LW-1:0]    ld_delay = '0;
    logic [NI-1:0]    ld_mask = '0;
    logic [NI*DW-1:0] ld_data = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             ld_ready;
    logic             busy;
    logic             done;
    logic [NI-1:0]    new_input;
    logic [NI*DW-1:0] input_data;
    logic [2:0]       fill;
    logic [15:0]      fired_cnt;

    stim_event_player #(
        .NUM_IN  (NI),
        .DATA_W  (DW),
        .DEPTH   (DP),
        .DELAY_W (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_delay   (ld_delay),
        .ld_mask    (ld_mask),
        .ld_data    (ld_data),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .new_input  (new_input),
        .input_data (input_data),
        .fill       (fill),
        .fired_cnt  (fired_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        logic [1:0]  mask;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        logic [31:0] dly;
        logic [1:0]  mask;
        logic [15:0] data;
        int          off;
    } vec_t;

    typedef struct {
        int first;
        int n;
        int done_off;
        int fired;
    } scn_t;

    ev_t  fire_q[$];
    int   done_q[$];
    vec_t vecs[10];
    scn_t scns[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_data(input logic [1:0] m, input logic [15:0] d);
        return {m[1] ? d[15:8] : 8'h00, m[0] ? d[7:0] : 8'h00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fire(input int c, input logic [1:0] m, input logic [15:0] d);
        ev_t e;
        e.cyc  = c;
        e.mask = m;
        e.data = exp_data(m, d);
        fire_q.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t ev;
        if (rst) begin
            if (new_input != '0) begin
                if (fire_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: got mask %0h data %0h (cycle %0d)", new_input, input_data, cyc);
                end else begin
                    ev = fire_q.pop_front();
                    check("fire_cycle", 64'(cyc), 64'(ev.cyc));
                    check("fire_mask", 64'(new_input), 64'(ev.mask));
                    check("fire_data", 64'(input_data), 64'(ev.data));
                end
            end else begin
                check("idle_data_zero", 64'(input_data), 64'd0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                end
            end
        end
    end

    task automatic load_entry(input logic [31:0] d, input logic [1:0] m, input logic [15:0] v);
        check("ld_ready_before_load", 64'(ld_ready), 64'd1);
        ld_valid = 1'b1;
        ld_delay = d;
        ld_mask  = m;
        ld_data  = v;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!busy && fire_q.size() == 0 && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: busy=%0d pending_fires=%0d pending_done=%0d, required all zero",
                     name, busy, fire_q.size(), done_q.size());
            fire_q.delete();
            done_q.delete();
        end
    endtask

    task automatic run_scn(input int s);
        int t0;
        for (int i = 0; i < scns[s].n; i++) begin
            vec_t v = vecs[scns[s].first + i];
            load_entry(v.dly, v.mask, v.data);
        end
        check("fill_loaded", 64'(fill), 64'(scns[s].n));
        if (scns[s].n == DP) begin
            check("ld_ready_full", 64'(ld_ready), 64'd0);
            ld_valid = 1'b1;
            ld_delay = 32'd0;
            ld_mask  = 2'b11;
            ld_data  = 16'hDEAD;
            tick();
            ld_valid = 1'b0;
            check("fill_full_hold", 64'(fill), 64'(DP));
        end
        start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < scns[s].n; i++) begin
            vec_t v = vecs[scns[s].first + i];
            if (v.off >= 0) push_fire(t0 + v.off, v.mask, v.data);
        end
        done_q.push_back(t0 + scns[s].done_off);
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        wait_idle("scenario");
        check("fired_cnt_end", 64'(fired_cnt), 64'(scns[s].fired));
        check("fill_end", 64'(fill), 64'd0);
        check("ld_ready_end", 64'(ld_ready), 64'd1);
    endtask

    initial begin
        int t0;
        vecs[0] = '{32'd0, 2'b01, 16'h0001, 1};
        vecs[1] = '{32'd6, 2'b01, 16'h0002, 9};
        vecs[2] = '{32'd0, 2'b01, 16'h0003, 11};
        vecs[3] = '{32'd0, 2'b10, 16'hF605, 1};
        vecs[4] = '{32'd3, 2'b00, 16'h1234, -1};
        vecs[5] = '{32'd0, 2'b01, 16'h0007, 8};
        vecs[6] = '{32'd0, 2'b11, 16'hA55A, 1};
        vecs[7] = '{32'd1, 2'b01, 16'h0011, 4};
        vecs[8] = '{32'd0, 2'b10, 16'h8000, 6};
        vecs[9] = '{32'd2, 2'b11, 16'h7F80, 10};
        scns[0] = '{0, 3, 12, 3};
        scns[1] = '{3, 3, 9, 2};
        scns[2] = '{6, 4, 11, 4};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_new_input", 64'(new_input), 64'd0);
        check("rst_input_data", 64'(input_data), 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_fired_cnt", 64'(fired_cnt), 64'd0);
        rst = 1'b1;
        tick();
        check("ld_ready_after_reset", 64'(ld_ready), 64'd1);

        // Start with empty buffer: done one cycle later, never busy
        start = 1'b1;
        done_q.push_back(cyc + 1);
        tick();
        start = 1'b0;
        check("empty_start_busy0", 64'(busy), 64'd0);
        tick();
        check("empty_start_busy1", 64'(busy), 64'd0);
        check("empty_start_done_seen", 64'(done_q.size()), 64'd0);

        for (int s = 0; s < 3; s++) run_scn(s);

        // en=0 for 3 cycles during WAIT slips the fire by 3; start while busy ignored
        load_entry(32'd5, 2'b01, 16'h0011);
        start = 1'b1;
        t0 = cyc;
        push_fire(t0 + 9, 2'b01, 16'h0011);
        done_q.push_back(t0 + 10);
        tick();
        start = 1'b0;
        tick();
        en = 1'b0;
        tick();
        check("en0_busy_hold", 64'(busy), 64'd1);
        tick();
        tick();
        en = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("enable");
        check("en_fired_cnt", 64'(fired_cnt), 64'd1);
        check("en_fill", 64'(fill), 64'd0);

        // abort mid-WAIT with entries still queued
        load_entry(32'd0, 2'b01, 16'h0021);
        load_entry(32'd10, 2'b01, 16'h0022);
        load_entry(32'd10, 2'b01, 16'h0023);
        load_entry(32'd10, 2'b01, 16'h0024);
        start = 1'b1;
        t0 = cyc;
        push_fire(t0 + 1, 2'b01, 16'h0021);
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("abort_pre_busy", 64'(busy), 64'd1);
        check("abort_pre_fill", 64'(fill), 64'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_fill", 64'(fill), 64'd0);
        check("abort_new_input", 64'(new_input), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_fired_hold", 64'(fired_cnt), 64'd1);
        repeat (15) tick();
        check("abort_ld_ready", 64'(ld_ready), 64'd1);
        check("abort_no_pending", 64'(fire_q.size()), 64'd0);

        // Asynchronous reset in the middle of a FIRE cycle
        load_entry(32'd0, 2'b10, 16'h5500);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fire_before_reset_mask", 64'(new_input), 64'h2);
        check("fire_before_reset_data", 64'(input_data), 64'h5500);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_new_input", 64'(new_input), 64'd0);
        check("async_rst_input_data", 64'(input_data), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("post_rst_ld_ready", 64'(ld_ready), 64'd1);
        check("post_rst_fill", 64'(fill), 64'd0);

        check("final_fire_q_empty", 64'(fire_q.size()), 64'd0);
        check("final_done_q_empty", 64'(done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
